// File: rtl/vrf_banked_regfile_pkg.sv
// Shared sizing, derived widths and transaction types for the banked vector register file.
package vrf_pkg;
  localparam int unsigned NBANK      = 4;
  localparam int unsigned BANK_RPORT = 2;
  localparam int unsigned BANK_WPORT = 1;
  localparam int unsigned RPORT      = 4;
  localparam int unsigned WPORT      = 2;
  localparam int unsigned NREG       = 64;
  localparam int unsigned VFULEN     = 64;
  localparam int unsigned V0_SEGS    = 2;

  localparam int unsigned BANK_W = $clog2(NBANK);
  localparam int unsigned ADDR_W = $clog2(NREG);
  localparam int unsigned ROW_W  = ADDR_W - BANK_W;
  localparam int unsigned NROW   = NREG / NBANK;
  localparam int unsigned PSEL_W = (BANK_RPORT > 1) ? $clog2(BANK_RPORT) : 1;
  localparam int unsigned RSRC_W = (RPORT > 1) ? $clog2(RPORT) : 1;
  localparam int unsigned WSRC_W = (WPORT > 1) ? $clog2(WPORT) : 1;

  typedef struct packed {
    logic [RPORT-1:0]             mask;
    logic [RPORT-1:0][ADDR_W-1:0] addr;
  } vrf_rd_req_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [VFULEN-1:0] mask;
    logic [VFULEN-1:0] data;
  } vrf_wr_t;

  function automatic logic [VFULEN-1:0] merge(input logic [VFULEN-1:0] old,
                                              input logic [VFULEN-1:0] mask,
                                              input logic [VFULEN-1:0] data);
    return (old & ~mask) | (data & mask);
  endfunction
endpackage

// File: rtl/vrf_banked_regfile_if.sv
// Dispatch-side read/write bus of the vector register file.
interface vrf_banked_regfile_if;
  import vrf_pkg::*;
  logic                      rd_req;
  logic                      rd_ready;
  logic [RPORT-1:0]          rd_mask;
  logic [RPORT*ADDR_W-1:0]   rd_addr;
  logic [RPORT-1:0]          rd_vld;
  logic [RPORT*VFULEN-1:0]   rd_data;
  logic                      rd_done;
  logic [WPORT-1:0]          wr_vld;
  logic [WPORT*ADDR_W-1:0]   wr_addr;
  logic [WPORT*VFULEN-1:0]   wr_mask;
  logic [WPORT*VFULEN-1:0]   wr_data;
  logic [WPORT-1:0]          wr_conflict;
  logic [V0_SEGS*VFULEN-1:0] v0_data;

  modport master (output rd_req, rd_mask, rd_addr, wr_vld, wr_addr, wr_mask, wr_data,
                  input  rd_ready, rd_vld, rd_data, rd_done, wr_conflict, v0_data);
  modport slave  (input  rd_req, rd_mask, rd_addr, wr_vld, wr_addr, wr_mask, wr_data,
                  output rd_ready, rd_vld, rd_data, rd_done, wr_conflict, v0_data);
endinterface

// File: rtl/vrf_banked_regfile_arbiter.sv
// Per-bank port allocator: lowest index first; same-row requests either share a port or lose.
module vrf_bank_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned NPORT = 2,
  parameter int unsigned ROW_W = 4,
  parameter int unsigned SRC_W = 2,
  parameter bit          SHARE = 1'b1
) (
  input  logic [N-1:0]                 req,
  input  logic [N-1:0][ROW_W-1:0]      row,
  output logic [N-1:0]                 gnt,
  output logic [NPORT-1:0]             port_vld,
  output logic [NPORT-1:0][ROW_W-1:0]  port_row,
  output logic [NPORT-1:0][SRC_W-1:0]  port_src
);
  always_comb begin : alloc
    logic hit;
    logic taken;
    gnt      = '0;
    port_vld = '0;
    port_row = '0;
    port_src = '0;
    hit      = 1'b0;
    taken    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      hit   = 1'b0;
      taken = 1'b0;
      if (req[i]) begin
        for (int unsigned p = 0; p < NPORT; p++)
          if (port_vld[p] && port_row[p] == row[i]) hit = 1'b1;
        if (!hit) begin
          for (int unsigned p = 0; p < NPORT; p++) begin
            if (!taken && !port_vld[p]) begin
              port_vld[p] = 1'b1;
              port_row[p] = row[i];
              port_src[p] = SRC_W'(i);
              taken       = 1'b1;
            end
          end
        end
        gnt[i] = hit ? SHARE : taken;
      end
    end
  end
endmodule

// File: rtl/vrf_banked_regfile_bank.sv
// Multi-port storage bank with registered read and bitwise-masked write; contents not reset.
module regfile_bank #(
  parameter int unsigned NROW  = 16,
  parameter int unsigned ROW_W = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned NRP   = 2,
  parameter int unsigned NWP   = 1
) (
  input  logic                      clk,
  input  logic [NRP-1:0]            re,
  input  logic [NRP-1:0][ROW_W-1:0] raddr,
  output logic [NRP-1:0][W-1:0]     rdata,
  input  logic [NWP-1:0]            we,
  input  logic [NWP-1:0][ROW_W-1:0] waddr,
  input  logic [NWP-1:0][W-1:0]     wmask,
  input  logic [NWP-1:0][W-1:0]     wdata
);
  logic [W-1:0] mem [NROW];

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NRP; p++)
      if (re[p]) rdata[p] <= mem[raddr[p]];
    for (int unsigned p = 0; p < NWP; p++)
      if (we[p]) mem[waddr[p]] <= (mem[waddr[p]] & ~wmask[p]) | (wdata[p] & wmask[p]);
  end
endmodule

// File: rtl/vrf_banked_regfile.sv
// Banked vector register file: multi-cycle operand drain, write back-pressure, RAW handling, v0 mirror.
// Optional: define VRF_WR_BYPASS_EN to forward same-cycle writes into read data instead of stalling.
module vrf_banked_regfile
  import vrf_pkg::*;
(
  input logic                 clk,
  input logic                 rstn,
  vrf_banked_regfile_if.slave bus
);
  vrf_rd_req_t                   cur;
  vrf_wr_t                       wr [WPORT];
  logic                          accept, rd_done_ff;
  logic [RPORT-1:0]              pending_ff, pending_nxt, elig, rd_gnt, rd_vld_ff;
  logic [RPORT-1:0][ADDR_W-1:0]  addr_ff;
  logic [RPORT-1:0][BANK_W-1:0]  bank_q;
  logic [RPORT-1:0][PSEL_W-1:0]  port_q, port_sel;
  logic [WPORT-1:0]              wr_gnt, wr_exec;
  logic [V0_SEGS-1:0][VFULEN-1:0] v0_ff;

  logic [RPORT-1:0]                        rgnt_b  [NBANK];
  logic [BANK_RPORT-1:0]                   rpvld_b [NBANK];
  logic [BANK_RPORT-1:0][ROW_W-1:0]        rprow_b [NBANK];
  logic [BANK_RPORT-1:0][RSRC_W-1:0]       rpsrc_b [NBANK];
  logic [BANK_RPORT-1:0][VFULEN-1:0]       rdata_b [NBANK];
  logic [WPORT-1:0]                        wgnt_b  [NBANK];
  logic [BANK_WPORT-1:0]                   wpvld_b [NBANK];
  logic [BANK_WPORT-1:0][ROW_W-1:0]        wprow_b [NBANK];
  logic [BANK_WPORT-1:0][WSRC_W-1:0]       wpsrc_b [NBANK];

  always_comb begin
    accept   = bus.rd_req && (pending_ff == '0);
    cur.mask = accept ? bus.rd_mask : pending_ff;
    cur.addr = accept ? bus.rd_addr : addr_ff;
    for (int unsigned j = 0; j < WPORT; j++) begin
      wr[j].vld  = bus.wr_vld[j];
      wr[j].addr = bus.wr_addr[j*ADDR_W +: ADDR_W];
      wr[j].mask = bus.wr_mask[j*VFULEN +: VFULEN];
      wr[j].data = bus.wr_data[j*VFULEN +: VFULEN];
    end
  end

  always_comb begin
    wr_gnt = '0;
    for (int unsigned b = 0; b < NBANK; b++) wr_gnt = wr_gnt | wgnt_b[b];
    wr_exec         = bus.wr_vld & wr_gnt;
    bus.wr_conflict = bus.wr_vld & ~wr_gnt;
  end

`ifdef VRF_WR_BYPASS_EN
  logic [RPORT-1:0][VFULEN-1:0] byp_mask, byp_data, byp_mask_ff, byp_data_ff;

  // Capture the grant-cycle write per operand; only consumed alongside the matching rd_vld.
  always_comb begin
    elig     = cur.mask;
    byp_mask = '0;
    byp_data = '0;
    for (int unsigned i = 0; i < RPORT; i++)
      for (int unsigned j = 0; j < WPORT; j++)
        if (wr_exec[j] && wr[j].addr == cur.addr[i]) begin
          byp_mask[i] = wr[j].mask;
          byp_data[i] = wr[j].data;
        end
  end

  always_ff @(posedge clk) begin
    byp_mask_ff <= byp_mask;
    byp_data_ff <= byp_data;
  end
`else
  logic [RPORT-1:0] raw;

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < RPORT; i++)
      for (int unsigned j = 0; j < WPORT; j++)
        if (wr_exec[j] && wr[j].addr == cur.addr[i]) raw[i] = 1'b1;
    elig = cur.mask & ~raw;
  end
`endif

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic [RPORT-1:0]                 rreq;
    logic [RPORT-1:0][ROW_W-1:0]      rrow;
    logic [WPORT-1:0]                 wreq;
    logic [WPORT-1:0][ROW_W-1:0]      wrow;
    logic [BANK_WPORT-1:0][VFULEN-1:0] wmask, wdata;

    always_comb begin
      rreq = '0;
      rrow = '0;
      wreq = '0;
      wrow = '0;
      for (int unsigned i = 0; i < RPORT; i++) begin
        rreq[i] = elig[i] && (cur.addr[i][BANK_W-1:0] == BANK_W'(b));
        rrow[i] = cur.addr[i][ADDR_W-1:BANK_W];
      end
      for (int unsigned j = 0; j < WPORT; j++) begin
        wreq[j] = wr[j].vld && (wr[j].addr[BANK_W-1:0] == BANK_W'(b));
        wrow[j] = wr[j].addr[ADDR_W-1:BANK_W];
      end
      wmask = '0;
      wdata = '0;
      for (int unsigned p = 0; p < BANK_WPORT; p++) begin
        wmask[p] = wr[wpsrc_b[b][p]].mask;
        wdata[p] = wr[wpsrc_b[b][p]].data;
      end
    end

    vrf_bank_arbiter #(.N(RPORT), .NPORT(BANK_RPORT), .ROW_W(ROW_W), .SRC_W(RSRC_W), .SHARE(1'b1)) u_rd_arb (
      .req(rreq), .row(rrow), .gnt(rgnt_b[b]),
      .port_vld(rpvld_b[b]), .port_row(rprow_b[b]), .port_src(rpsrc_b[b]));

    vrf_bank_arbiter #(.N(WPORT), .NPORT(BANK_WPORT), .ROW_W(ROW_W), .SRC_W(WSRC_W), .SHARE(1'b0)) u_wr_arb (
      .req(wreq), .row(wrow), .gnt(wgnt_b[b]),
      .port_vld(wpvld_b[b]), .port_row(wprow_b[b]), .port_src(wpsrc_b[b]));

    regfile_bank #(.NROW(NROW), .ROW_W(ROW_W), .W(VFULEN), .NRP(BANK_RPORT), .NWP(BANK_WPORT)) u_bank (
      .clk(clk), .re(rpvld_b[b]), .raddr(rprow_b[b]), .rdata(rdata_b[b]),
      .we(wpvld_b[b]), .waddr(wprow_b[b]), .wmask(wmask), .wdata(wdata));
  end

  // A sharing operand reads from whichever port its same-address owner was given.
  always_comb begin
    rd_gnt   = '0;
    port_sel = '0;
    for (int unsigned b = 0; b < NBANK; b++) rd_gnt = rd_gnt | rgnt_b[b];
    for (int unsigned i = 0; i < RPORT; i++)
      for (int unsigned b = 0; b < NBANK; b++)
        for (int unsigned p = 0; p < BANK_RPORT; p++)
          if (cur.addr[i][BANK_W-1:0] == BANK_W'(b) && rpvld_b[b][p] &&
              cur.addr[rpsrc_b[b][p]] == cur.addr[i])
            port_sel[i] = PSEL_W'(p);
    pending_nxt = cur.mask & ~rd_gnt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending_ff <= '0;
      rd_vld_ff  <= '0;
      rd_done_ff <= 1'b0;
      v0_ff      <= '0;
    end else begin
      pending_ff <= pending_nxt;
      rd_vld_ff  <= rd_gnt;
      rd_done_ff <= (accept || pending_ff != '0) && pending_nxt == '0;
      for (int unsigned s = 0; s < V0_SEGS; s++)
        for (int unsigned j = 0; j < WPORT; j++)
          if (wr_exec[j] && wr[j].addr == ADDR_W'(s))
            v0_ff[s] <= merge(v0_ff[s], wr[j].mask, wr[j].data);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_ff <= bus.rd_addr;
    for (int unsigned i = 0; i < RPORT; i++) bank_q[i] <= cur.addr[i][BANK_W-1:0];
    port_q <= port_sel;
  end

  always_comb begin
    bus.rd_ready = (pending_ff == '0);
    bus.rd_vld   = rd_vld_ff;
    bus.rd_done  = rd_done_ff;
    bus.v0_data  = v0_ff;
    bus.rd_data  = '0;
    for (int unsigned i = 0; i < RPORT; i++)
`ifdef VRF_WR_BYPASS_EN
      bus.rd_data[i*VFULEN +: VFULEN] = merge(rdata_b[bank_q[i]][port_q[i]], byp_mask_ff[i], byp_data_ff[i]);
`else
      bus.rd_data[i*VFULEN +: VFULEN] = rdata_b[bank_q[i]][port_q[i]];
`endif
  end
endmodule

// File: tb/tb_vrf_banked_regfile.sv
// Directed bench for vrf_banked_regfile: shadow memory model plus a cycle-stamped read scoreboard.
module tb_vrf_banked_regfile;
  import vrf_pkg::*;

  typedef struct packed {
    int              cyc;
    logic [3:0]      vld;
    logic            done;
    logic [3:0][63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [63:0] mem_m [64];

  vrf_banked_regfile_if bus ();
  vrf_banked_regfile dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int unsigned p, input logic [5:0] a, input logic [63:0] m, input logic [63:0] d);
    bus.wr_vld[p]           = 1'b1;
    bus.wr_addr[p*6 +: 6]   = a;
    bus.wr_mask[p*64 +: 64] = m;
    bus.wr_data[p*64 +: 64] = d;
  endtask

  task automatic clr_wr();
    bus.wr_vld  = '0;
    bus.wr_addr = '0;
    bus.wr_mask = '0;
    bus.wr_data = '0;
  endtask

  task automatic issue(input logic [3:0] m, input logic [3:0][5:0] a);
    bus.rd_req  = 1'b1;
    bus.rd_mask = m;
    bus.rd_addr = a;
  endtask

  task automatic push(input int c, input logic [3:0] v, input logic d, input logic [3:0][5:0] a);
    exp_t e;
    e.cyc  = c;
    e.vld  = v;
    e.done = d;
    e.data = '0;
    for (int i = 0; i < 4; i++) if (v[i]) e.data[i] = mem_m[a[i]];
    sb.push_back(e);
  endtask

  // Every cycle: either the queued event for this cycle or a quiet read bus.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("sb_missed_cycle", 128'(cyc), 128'(e.cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("rd_vld", 128'(bus.rd_vld), 128'(e.vld));
      chk("rd_done", 128'(bus.rd_done), 128'(e.done));
      for (int i = 0; i < 4; i++)
        if (e.vld[i]) chk("rd_data", 128'(bus.rd_data[i*64 +: 64]), 128'(e.data[i]));
    end else begin
      chk("rd_vld_idle", 128'(bus.rd_vld), 128'(0));
      chk("rd_done_idle", 128'(bus.rd_done), 128'(0));
    end
  end

  initial begin
    int t;
    logic [63:0] d, m;
    bus.rd_req = 1'b0;
    bus.rd_mask = '0;
    bus.rd_addr = '0;
    clr_wr();
    #1 rstn = 1'b0;
    #2;
    chk("reset_rd_ready", 128'(bus.rd_ready), 128'(1));
    chk("reset_rd_vld", 128'(bus.rd_vld), 128'(0));
    chk("reset_rd_done", 128'(bus.rd_done), 128'(0));
    chk("reset_v0", 128'(bus.v0_data), 128'(0));
    repeat (3) step();
    rstn = 1'b1;

    // Fill every entry; paired writes hit adjacent (different) banks.
    for (int a = 0; a < 64; a += 2) begin
      step();
      d = (a == 0) ? '1 : {$urandom, $urandom};
      m = {$urandom, $urandom};
      set_wr(0, 6'(a), '1, d);
      set_wr(1, 6'(a + 1), '1, m);
      #2 chk("init_wr_conflict", 128'(bus.wr_conflict), 128'(0));
      mem_m[a] = d;
      mem_m[a + 1] = m;
    end
    step();
    clr_wr();

    // Four operands, one bank, two ports: drains over two cycles.
    issue(4'b1111, {6'd16, 6'd12, 6'd8, 6'd4});
    t = cyc;
    push(t + 1, 4'b0011, 1'b0, {6'd16, 6'd12, 6'd8, 6'd4});
    push(t + 2, 4'b1100, 1'b1, {6'd16, 6'd12, 6'd8, 6'd4});
    #2 chk("t1_ready_T", 128'(bus.rd_ready), 128'(1));
    step();
    bus.rd_req = 1'b0;
    #2 chk("t1_ready_T1", 128'(bus.rd_ready), 128'(0));
    step();
    #2 chk("t1_ready_T2", 128'(bus.rd_ready), 128'(1));

    // Same address four times shares a single port.
    issue(4'b1111, {6'd7, 6'd7, 6'd7, 6'd7});
    push(cyc + 1, 4'b1111, 1'b1, {6'd7, 6'd7, 6'd7, 6'd7});
    step();
    bus.rd_req = 1'b0;

    // Mixed row sharing and port exhaustion in bank 1.
    step();
    issue(4'b1111, {6'd9, 6'd1, 6'd5, 6'd1});
    push(cyc + 1, 4'b0111, 1'b0, {6'd9, 6'd1, 6'd5, 6'd1});
    push(cyc + 2, 4'b1000, 1'b1, {6'd9, 6'd1, 6'd5, 6'd1});
    step();
    bus.rd_req = 1'b0;
    step();

    // Empty request: accepted, done only.
    issue(4'b0000, {6'd0, 6'd0, 6'd0, 6'd0});
    push(cyc + 1, 4'b0000, 1'b1, {6'd0, 6'd0, 6'd0, 6'd0});
    step();
    bus.rd_req = 1'b0;

    // Write-port conflict in bank 1, then retry of the loser.
    step();
    d = {$urandom, $urandom};
    m = 64'hFFFF_0000_FFFF_0000;
    set_wr(0, 6'd5, m, d);
    set_wr(1, 6'd9, '1, 64'h1234_5678_9ABC_DEF0);
    #2 chk("t3_conflict", 128'(bus.wr_conflict), 128'(2'b10));
    step();
    mem_m[5] = (mem_m[5] & ~m) | (d & m);
    bus.wr_vld[0] = 1'b0;
    #2 chk("t3_retry_conflict", 128'(bus.wr_conflict), 128'(2'b00));
    step();
    mem_m[9] = 64'h1234_5678_9ABC_DEF0;
    clr_wr();

    // Same address on both write ports: higher port loses.
    set_wr(0, 6'd10, '1, 64'hCAFE_F00D_0000_0001);
    set_wr(1, 6'd10, '1, 64'hDEAD_BEEF_0000_0002);
    #2 chk("same_addr_conflict", 128'(bus.wr_conflict), 128'(2'b10));
    step();
    mem_m[10] = 64'hCAFE_F00D_0000_0001;
    clr_wr();
    issue(4'b0111, {6'd0, 6'd10, 6'd5, 6'd9});
    push(cyc + 1, 4'b0111, 1'b1, {6'd0, 6'd10, 6'd5, 6'd9});
    step();
    bus.rd_req = 1'b0;

    // Masked write into v0.
    step();
    set_wr(0, 6'd0, 64'hFF, 64'h0);
    step();
    clr_wr();
    mem_m[0] = 64'hFFFF_FFFF_FFFF_FF00;
    #2;
    chk("t4_v0_lo", 128'(bus.v0_data[63:0]), 128'(64'hFFFF_FFFF_FFFF_FF00));
    chk("t4_v0_hi", 128'(bus.v0_data[127:64]), 128'(mem_m[1]));
    issue(4'b0001, {6'd0, 6'd0, 6'd0, 6'd0});
    push(cyc + 1, 4'b0001, 1'b1, {6'd0, 6'd0, 6'd0, 6'd0});
    step();
    bus.rd_req = 1'b0;

    // Read-after-write on addr 3 in the same cycle.
    step();
    set_wr(0, 6'd3, '1, 64'hAAAA);
    issue(4'b0001, {6'd0, 6'd0, 6'd0, 6'd3});
    mem_m[3] = 64'hAAAA;
`ifdef VRF_WR_BYPASS_EN
    push(cyc + 1, 4'b0001, 1'b1, {6'd0, 6'd0, 6'd0, 6'd3});
`else
    push(cyc + 2, 4'b0001, 1'b1, {6'd0, 6'd0, 6'd0, 6'd3});
`endif
    step();
    clr_wr();
    bus.rd_req = 1'b0;
`ifdef VRF_WR_BYPASS_EN
    #2 chk("t5_ready_T1", 128'(bus.rd_ready), 128'(1));
`else
    #2 chk("t5_ready_T1", 128'(bus.rd_ready), 128'(0));
`endif
    step();
    step();

    // Reset mid-request: the queued pulses must never appear.
    issue(4'b1111, {6'd16, 6'd12, 6'd8, 6'd4});
    step();
    bus.rd_req = 1'b0;
    chk("t6_pending_ready", 128'(bus.rd_ready), 128'(0));
    chk("t6_first_vld", 128'(bus.rd_vld), 128'(4'b0011));
    rstn = 1'b0;
    #1;
    chk("t6_rst_ready", 128'(bus.rd_ready), 128'(1));
    chk("t6_rst_vld", 128'(bus.rd_vld), 128'(0));
    chk("t6_rst_v0", 128'(bus.v0_data), 128'(0));
    repeat (2) step();
    rstn = 1'b1;
    repeat (4) step();
    chk("t6_post_ready", 128'(bus.rd_ready), 128'(1));

    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("sb_drain", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vrf_banked_regfile.md
Name: vrf_banked_regfile

Overview:
- Parametrised, multi-cycle-scheduled vector register file.
- Storage is split across NBANK synchronous-read banks; each bank has BANK_RPORT read ports and BANK_WPORT write ports.
- A multi-operand read request from the vector dispatch queue is latched once, then drained over one or more cycles as bank ports free up; each operand's data is returned with a valid strobe.
- Write-port bank conflicts are back-pressured, and read-after-write hazards are handled in hardware. Also keeps a live mirror of architectural v0 for mask consumers.

Parameters:
- NBANK, 4, number of banks (power of two, >=2)
- BANK_RPORT, 2, read ports per bank
- BANK_WPORT, 1, write ports per bank
- RPORT, 4, read operands per request
- WPORT, 2, write ports
- NREG, 64, total VFULEN-wide entries (power of two, multiple of NBANK)
- VFULEN, 64, entry width in bits
- V0_SEGS, 2, entries forming v0 (addresses 0..V0_SEGS-1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- rd_req  in  1  read request valid
- rd_ready  out  1  request accepted when rd_req & rd_ready
- rd_mask  in  RPORT  operand valid bits
- rd_addr  in  RPORT*log2(NREG)  operand addresses
- rd_vld  out  RPORT  per-operand data valid, one-cycle pulse
- rd_data  out  RPORT*VFULEN  operand data
- rd_done  out  1  pulses with the last rd_vld of a request
- wr_vld  in  WPORT  write valid
- wr_addr  in  WPORT*log2(NREG)  write address
- wr_mask  in  WPORT*VFULEN  bit write enable
- wr_data  in  WPORT*VFULEN  write data
- wr_conflict  out  WPORT  combinational; write not performed, source holds and retries
- v0_data  out  V0_SEGS*VFULEN  current v0 contents

Behaviour:
- Address mapping: bank = addr[log2(NBANK)-1:0], row = addr >> log2(NBANK).
- Reset values: pending=0, rd_vld=0, rd_done=0, rd_ready=1, v0 mirror=0. Bank contents are not reset.
- rd_ready = (pending_ff == 0).
- On accept at cycle T:
  - addresses are latched;
  - the candidate set is rd_mask, and grants are computed the same cycle from the incoming addresses;
  - later cycles use pending_ff and the latched addresses.
- Per bank, each cycle:
  - candidates targeting the bank are ordered by operand index, lowest first;
  - distinct rows take bank ports lowest-index first, up to BANK_RPORT;
  - candidates with a row identical to a granted row share that port and are granted too;
  - ungranted candidates stay in pending.
- A granted operand at cycle t yields rd_vld[i]=1 and rd_data[i] at t+1 (registered).
- rd_done=1 in the cycle the last rd_vld of the request is asserted.
- A request with rd_mask=0: accepted, no rd_vld, rd_done pulses at T+1.
- RAW hazard: a candidate whose address equals a write executed in the same cycle (wr_vld & ~wr_conflict) is not granted that cycle; it is retried next cycle and sees the new data.
- Write arbitration, per bank:
  - valid writes are ordered by port index, lowest first;
  - up to BANK_WPORT are executed;
  - excess writes get wr_conflict=1;
  - two writes to the same address in one cycle: the lower index executes, the higher gets wr_conflict.
- Write semantics: bitwise, entry = (entry & ~mask) | (data & mask), committed at the clock edge.
- v0 mirror receives the same masked update, visible on v0_data the next cycle.
- Reset asserted mid-request: pending cleared, outstanding rd_vld suppressed, request lost; the source reissues.

Optional Feature:
- Macro: VRF_WR_BYPASS_EN.
- Defined: RAW candidates are not stalled. They are granted normally, and the registered rd_data is merged as (bank_rdata & ~wmask) | (wdata & wmask) using the write executed in the grant cycle.
- Undefined: stall-and-retry as described in Behaviour.

Decomposition:
- Shared package vrf_pkg holds:
  - parameters and derived widths (BANK_W, ROW_W, ADDR_W);
  - typedefs vrf_rd_req_t {mask, addr[]} and vrf_wr_t {vld, addr, mask, data}.
- One sub-module, vrf_bank_arbiter, is instantiated per bank for reads (row sharing on) and for writes (sharing off, same-address conflict on). It outputs grant vector, per-port row, and per-port source index.
- Bank storage reuses regfile_bank, generalised to BANK_RPORT/BANK_WPORT ports with registered read.

Test Plan (NBANK=4, BANK_RPORT=2, BANK_WPORT=1, RPORT=4, WPORT=2, VFULEN=64):
1. Read {4,8,12,16}, mask 1111, at T -> rd_vld=0011 at T+1; rd_vld=1100 and rd_done at T+2; rd_ready low at T+1, high at T+2.
2. Read {7,7,7,7} -> all four share one bank-3 port; rd_vld=1111 and rd_done at T+1, all data equal.
3. Writes addr 5 and 9 (both bank 1) same cycle -> wr_conflict=10, addr 5 written; retry of 9 next cycle -> wr_conflict=00, a later read of 9 returns the written data.
4. Entry 0 = all ones; write addr 0, mask 0xFF, data 0 -> v0_data[63:0]=0xFFFF_FFFF_FFFF_FF00 next cycle, and a read of 0 returns the same value.
5. Write addr 3 = 0xAAAA (full mask) at T while reading addr 3 -> without macro: rd_vld at T+2 with 0xAAAA; with VRF_WR_BYPASS_EN: rd_vld at T+1 with 0xAAAA.
6. rstn low while pending=1100 -> rd_ready=1, rd_vld=0, v0_data=0 immediately; no rd_vld after release.
